counter_countdown: RTL and testbench



---
 rtl/counter_countdown_pkg.sv | 7 +
 rtl/counter_countdown.sv | 84 ++++++++
 tb/tb_counter_countdown.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/counter_countdown_pkg.sv
// counter_countdown_pkg: shared state encoding and count-width helper for the countdown timer.
package counter_countdown_pkg;
   typedef enum logic [1:0] {IDLE, RUN, PAUSE} cd_state_t;
   function automatic int cnt_width(input int max);
      return $clog2(max + 1);
   endfunction
endpackage

// File: rtl/counter_countdown.sv
// counter_countdown: loadable down-counter with pause, abort, one-shot/periodic reload and expiry pulse.
module counter_countdown
   import counter_countdown_pkg::*;
#(
   parameter int MAX = 12,
   localparam int W = cnt_width(MAX)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] d_i,
   input  logic         mode_i,
   input  logic         start_valid_i,
   output logic         start_ready_o,
   input  logic         pause_i,
   input  logic         abort_i,
   output logic [W-1:0] q_o,
   output logic         busy_o,
   output logic         paused_o,
   output logic         expire_o,
   output logic         err_o
);
   localparam logic [W-1:0] MAX_W = W'(MAX);
   cd_state_t    state_q, state_d;
   logic [W-1:0] cnt_q, cnt_d, reload_q, reload_d, v;
   logic         mode_q, mode_d, expire_q, expire_d, err_q, err_d, accept;
   assign start_ready_o = (state_q == IDLE) & ~abort_i;
   assign accept        = start_valid_i & start_ready_o;
   assign v             = (d_i > MAX_W) ? MAX_W : d_i;
   assign q_o           = cnt_q;
   assign busy_o        = state_q != IDLE;
   assign paused_o      = state_q == PAUSE;
   assign expire_o      = expire_q;
   assign err_o         = err_q;
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      reload_d = reload_q;
      mode_d   = mode_q;
      expire_d = 1'b0;
      err_d    = 1'b0;
      if (abort_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (accept) begin
         err_d    = d_i > MAX_W;
         reload_d = v;
         mode_d   = mode_i;
         state_d  = (v == '0) ? IDLE : RUN;
         cnt_d    = v;
         expire_d = v == '0;
      end else if (state_q != IDLE) begin
         if (pause_i) begin
            state_d = PAUSE;
         end else begin
            state_d = RUN;
            // terminal step: reload in periodic mode, otherwise fall back to idle
            if (cnt_q > W'(1)) begin
               cnt_d = cnt_q - W'(1);
            end else begin
               expire_d = 1'b1;
               cnt_d    = mode_q ? reload_q : '0;
               state_d  = mode_q ? RUN : IDLE;
            end
         end
      end
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         reload_q <= '0;
         mode_q   <= 1'b0;
         expire_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
         mode_q   <= mode_d;
         expire_q <= expire_d;
         err_q    <= err_d;
      end
   end
endmodule

// File: tb/tb_counter_countdown.sv
// tb_counter_countdown: scoreboard-driven checks of the countdown timer with MAX=12.
module tb_counter_countdown;
   localparam int W = 4;
   typedef struct packed {logic [W-1:0] q; logic ex; logic busy; logic pz;} exp_t;
   logic clk = 1'b0, rst = 1'b1;
   logic [W-1:0] d = '0;
   logic mode = 1'b0, start_valid = 1'b0, pause = 1'b0, abort = 1'b0;
   logic start_ready, busy, paused, expire, err;
   logic [W-1:0] q;
   exp_t sb[$];
   exp_t e, got;
   int checks = 0, failures = 0;

   counter_countdown #(.MAX(12)) dut (
      .clk_i(clk), .rst_i(rst), .d_i(d), .mode_i(mode), .start_valid_i(start_valid),
      .start_ready_o(start_ready), .pause_i(pause), .abort_i(abort), .q_o(q),
      .busy_o(busy), .paused_o(paused), .expire_o(expire), .err_o(err)
   );

   always #5 clk = ~clk;
   assign got = {q, expire, busy, paused};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [W-1:0] dv, input logic mv);
      @(negedge clk);
      d = dv; mode = mv; start_valid = 1'b1;
      tick();
      start_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; sb.size() > 0; i++) begin
         if (i > 0) tick();
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL %s cycle %0d got q/exp/busy/paused=%h exp %h", name, i, got, e);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      checks += 5;
      if (q !== 4'd0) begin failures++; $display("FAIL reset_q got %0d exp 0", q); end
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
      if (expire !== 1'b0) begin failures++; $display("FAIL reset_expire got %b exp 0", expire); end
      if (err !== 1'b0) begin failures++; $display("FAIL reset_err got %b exp 0", err); end
      if (start_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b exp 1", start_ready); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_oneshot();
      start(4'd3, 1'b0);
      sb.push_back('{4'd3, 1'b0, 1'b1, 1'b0});
      sb.push_back('{4'd2, 1'b0, 1'b1, 1'b0});
      sb.push_back('{4'd1, 1'b0, 1'b1, 1'b0});
      sb.push_back('{4'd0, 1'b1, 1'b0, 1'b0});
      drain("oneshot");
      checks++;
      if (start_ready !== 1'b1) begin failures++; $display("FAIL oneshot_ready got %b exp 1", start_ready); end
      tick();
      checks++;
      if (expire !== 1'b0) begin failures++; $display("FAIL oneshot_pulse_width got %b exp 0", expire); end
   endtask

   task automatic test_periodic();
      start(4'd2, 1'b1);
      for (int i = 0; i < 5; i++) sb.push_back('{(i % 2) ? 4'd1 : 4'd2, (i > 0) && (i % 2 == 0), 1'b1, 1'b0});
      drain("periodic");
      @(negedge clk);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      sb.push_back('{4'd0, 1'b0, 1'b0, 1'b0});
      for (int i = 0; i < 3; i++) sb.push_back('{4'd0, 1'b0, 1'b0, 1'b0});
      drain("periodic_abort");
   endtask

   task automatic test_pause();
      int m = 5;
      start(4'd5, 1'b0);
      sb.push_back('{4'd5, 1'b0, 1'b1, 1'b0});
      drain("pause_accept");
      for (int j = 1; j <= 8; j++) begin
         @(negedge clk);
         pause = (j >= 3) && (j <= 5);
         if (!pause) m--;
         tick();
         sb.push_back('{W'(m), m == 0, m != 0, pause});
         drain("pause");
      end
      pause = 1'b0;
   endtask

   task automatic test_clamp_zero();
      int n = 0;
      start(4'd15, 1'b0);
      checks += 2;
      if (err !== 1'b1) begin failures++; $display("FAIL clamp_err got %b exp 1", err); end
      if (q !== 4'd12) begin failures++; $display("FAIL clamp_q got %0d exp 12", q); end
      while (expire !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (n !== 12) begin failures++; $display("FAIL clamp_expire_delay got %0d exp 12", n); end
      start(4'd0, 1'b0);
      sb.push_back('{4'd0, 1'b1, 1'b0, 1'b0});
      sb.push_back('{4'd0, 1'b0, 1'b0, 1'b0});
      drain("zero");
      checks++;
      if (err !== 1'b0) begin failures++; $display("FAIL zero_err got %b exp 0", err); end
   endtask

   task automatic test_handshake();
      start(4'd4, 1'b0);
      @(negedge clk);
      d = 4'd9; start_valid = 1'b1;
      #1;
      checks++;
      if (start_ready !== 1'b0) begin failures++; $display("FAIL busy_ready got %b exp 0", start_ready); end
      tick();
      start_valid = 1'b0;
      sb.push_back('{4'd3, 1'b0, 1'b1, 1'b0});
      sb.push_back('{4'd2, 1'b0, 1'b1, 1'b0});
      sb.push_back('{4'd1, 1'b0, 1'b1, 1'b0});
      sb.push_back('{4'd0, 1'b1, 1'b0, 1'b0});
      drain("ignore_start");
      @(negedge clk);
      abort = 1'b1; start_valid = 1'b1; d = 4'd5;
      #1;
      checks++;
      if (start_ready !== 1'b0) begin failures++; $display("FAIL abort_ready got %b exp 0", start_ready); end
      tick();
      abort = 1'b0; start_valid = 1'b0;
      sb.push_back('{4'd0, 1'b0, 1'b0, 1'b0});
      drain("abort_start");
   endtask

   task automatic test_reset_mid();
      start(4'd10, 1'b0);
      repeat (2) tick();
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({q, busy} !== 5'd0) begin failures++; $display("FAIL midreset got q=%0d busy=%b exp 0/0", q, busy); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_periodic();
      test_pause();
      test_clamp_zero();
      test_handshake();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
